dma_copy_engine: RTL and testbench

Single-channel DMA copy engine and AXI4-Lite master. It sits directly upstream of the AXI4-Lite word memory and moves LEN 32-bit words from SRC to DST with one read then one write per word. A descriptor is loaded by a start pulse from the DMAC control/register block, and completion is reported back as done/error. There is one transaction in flight at a time, with no bursts.

---
 rtl/dmac_pkg.sv | 28 ++
 rtl/dma_copy_engine.sv | 184 ++++++++++++++++++
 tb/tb_dma_copy_engine.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmac_pkg.sv
// Shared types and constants for the single-channel DMA copy engine.
package dmac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR,
        ST_WR_RESP,
        ST_DONE
    } dma_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int unsigned WORD_BYTES = 4;

    // EXOKAY has no meaning on AXI4-Lite, so anything but OKAY aborts the transfer.
    function automatic logic resp_is_error(input logic [1:0] resp);
        case (resp)
            AXI_RESP_OKAY:                   return 1'b0;
            AXI_RESP_SLVERR, AXI_RESP_DECERR: return 1'b1;
            default:                         return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dma_copy_engine.sv
// Single-channel AXI4-Lite DMA copy engine: one read then one write per word.
// Optional `DMAC_FILL_EN adds fill_mode/fill_data ports for pattern fill.
module dma_copy_engine
    import dmac_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   src_addr,
    input  logic [ADDR_WIDTH-1:0]   dst_addr,
    input  logic [LEN_WIDTH-1:0]    len,
`ifdef DMAC_FILL_EN
    input  logic                    fill_mode,
    input  logic [DATA_WIDTH-1:0]   fill_data,
`endif
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [LEN_WIDTH-1:0]    words_left,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(WORD_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(WORD_BYTES - 1);

    dma_state_t state;
    logic       aw_done;
    logic       w_done;
    logic       aw_fire;
    logic       w_fire;
`ifdef DMAC_FILL_EN
    logic       fill_r;
`endif

    assign aw_fire     = m_axi_awvalid && m_axi_awready;
    assign w_fire      = m_axi_wvalid && m_axi_wready;
    assign m_axi_wstrb = '1;

    // The araddr/awaddr registers double as the running source/destination pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            words_left    <= '0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
`ifdef DMAC_FILL_EN
            fill_r        <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy         <= 1'b1;
                        error        <= 1'b0;
                        m_axi_araddr <= src_addr & ALIGN_MASK;
                        m_axi_awaddr <= dst_addr & ALIGN_MASK;
                        words_left   <= len;
`ifdef DMAC_FILL_EN
                        fill_r       <= fill_mode;
`endif
                        if (len == '0) begin
                            state <= ST_DONE;
`ifdef DMAC_FILL_EN
                        end else if (fill_mode) begin
                            m_axi_wdata   <= fill_data;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                            state         <= ST_WR;
`endif
                        end else begin
                            m_axi_arvalid <= 1'b1;
                            state         <= ST_RD_ADDR;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        if (resp_is_error(m_axi_rresp)) begin
                            error <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            m_axi_wdata   <= m_axi_rdata;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                            state         <= ST_WR;
                        end
                    end
                end
                ST_WR: begin
                    if (aw_fire) begin
                        m_axi_awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_fire) begin
                        m_axi_wvalid <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                        m_axi_bready <= 1'b1;
                        state        <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        if (resp_is_error(m_axi_bresp)) begin
                            error <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            m_axi_araddr <= m_axi_araddr + ADDR_STEP;
                            m_axi_awaddr <= m_axi_awaddr + ADDR_STEP;
                            words_left   <= words_left - 1'b1;
                            if (words_left == LEN_WIDTH'(1)) begin
                                state <= ST_DONE;
`ifdef DMAC_FILL_EN
                            end else if (fill_r) begin
                                m_axi_awvalid <= 1'b1;
                                m_axi_wvalid  <= 1'b1;
                                aw_done       <= 1'b0;
                                w_done        <= 1'b0;
                                state         <= ST_WR;
`endif
                            end else begin
                                m_axi_arvalid <= 1'b1;
                                state         <= ST_RD_ADDR;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Bench for dma_copy_engine: AXI4-Lite slave memory with programmable latency and
// error injection, a word-level copy model, table vectors and random transfers.
module tb_dma_copy_engine;
    import dmac_pkg::*;

    localparam int unsigned NONE  = 999;
    localparam int unsigned LIMIT = 500;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] len;
    logic        fill_mode;
    logic [31:0] fill_data;
    logic        busy, done, error;
    logic [15:0] words_left;
    logic [31:0] m_axi_araddr, m_axi_rdata, m_axi_awaddr, m_axi_wdata;
    logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready;
    logic [1:0]  m_axi_rresp, m_axi_bresp;
    logic [3:0]  m_axi_wstrb;

    always #5 clk = ~clk;

    dma_copy_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
`ifdef DMAC_FILL_EN
        .fill_mode(fill_mode), .fill_data(fill_data),
`endif
        .busy(busy), .done(done), .error(error), .words_left(words_left),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready), .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    // ---------------- slave memory ----------------
    logic [31:0] mem [0:1023];
    logic [31:0] mdl [0:1023];
    logic        init_mem;
    int unsigned ar_lat, r_lat, aw_lat, w_lat, b_lat, rd_err, wr_err;
    int unsigned ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, rd_idx, wr_idx, ar_cyc, aw_cyc;
    int unsigned cur_aw_lat, cur_w_lat;
    logic        r_pend, b_pend, aw_have, w_have, aw_hs, w_hs, wr_fire;
    logic [31:0] r_addr, aw_q, w_q, wr_addr_eff, wr_data_eff;
    logic [31:0] wlog_a[$], wlog_d[$], rlog[$];

    // Odd-numbered words swap the AW/W latencies so skew alternates direction.
    assign cur_aw_lat    = wr_idx[0] ? w_lat : aw_lat;
    assign cur_w_lat     = wr_idx[0] ? aw_lat : w_lat;
    assign m_axi_arready = m_axi_arvalid && (ar_cnt >= ar_lat);
    assign m_axi_rvalid  = r_pend && (r_cnt >= r_lat);
    assign m_axi_rdata   = mem[r_addr[11:2]];
    assign m_axi_rresp   = (rd_idx == rd_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign m_axi_awready = m_axi_awvalid && (aw_cnt >= cur_aw_lat);
    assign m_axi_wready  = m_axi_wvalid && (w_cnt >= cur_w_lat);
    assign m_axi_bvalid  = b_pend && (b_cnt >= b_lat);
    assign m_axi_bresp   = (wr_idx == wr_err) ? AXI_RESP_DECERR : AXI_RESP_OKAY;
    assign aw_hs         = m_axi_awvalid && m_axi_awready;
    assign w_hs          = m_axi_wvalid && m_axi_wready;
    assign wr_fire       = (aw_have || aw_hs) && (w_have || w_hs);
    assign wr_addr_eff   = aw_have ? aw_q : m_axi_awaddr;
    assign wr_data_eff   = w_have ? w_q : m_axi_wdata;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'(i + 1);
        end
        if (rst) begin
            r_pend <= 1'b0; b_pend <= 1'b0; aw_have <= 1'b0; w_have <= 1'b0;
            ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
        end else begin
            if (m_axi_arvalid) ar_cyc <= ar_cyc + 1;
            if (m_axi_awvalid) aw_cyc <= aw_cyc + 1;
            if (m_axi_arvalid && m_axi_arready) begin
                r_pend <= 1'b1; r_addr <= m_axi_araddr; ar_cnt <= 0;
                rlog.push_back(m_axi_araddr);
            end else if (m_axi_arvalid) ar_cnt <= ar_cnt + 1;
            if (m_axi_rvalid && m_axi_rready) begin
                r_pend <= 1'b0; r_cnt <= 0; rd_idx <= rd_idx + 1;
            end else if (r_pend) r_cnt <= r_cnt + 1;
            if (aw_hs) begin aw_have <= 1'b1; aw_q <= m_axi_awaddr; aw_cnt <= 0; end
            else if (m_axi_awvalid) aw_cnt <= aw_cnt + 1;
            if (w_hs) begin w_have <= 1'b1; w_q <= m_axi_wdata; w_cnt <= 0; end
            else if (m_axi_wvalid) w_cnt <= w_cnt + 1;
            if (wr_fire) begin
                mem[wr_addr_eff[11:2]] <= wr_data_eff;
                wlog_a.push_back(wr_addr_eff);
                wlog_d.push_back(wr_data_eff);
                aw_have <= 1'b0; w_have <= 1'b0; b_pend <= 1'b1;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                b_pend <= 1'b0; b_cnt <= 0; wr_idx <= wr_idx + 1;
            end else if (b_pend) b_cnt <= b_cnt + 1;
            if (start) begin
                rd_idx <= 0; wr_idx <= 0; ar_cyc <= 0; aw_cyc <= 0;
                wlog_a.delete(); wlog_d.delete(); rlog.delete();
            end
        end
    end

    // ---------------- valid/payload stability monitor ----------------
    logic        chk_ar = 1'b0, chk_aw = 1'b0, chk_w = 1'b0;
    logic [31:0] prev_ar, prev_aw, prev_w;
    int unsigned stab_viol = 0;
    always @(posedge clk) begin
        if (!rst && ((chk_ar && (!m_axi_arvalid || m_axi_araddr != prev_ar)) ||
                     (chk_aw && (!m_axi_awvalid || m_axi_awaddr != prev_aw)) ||
                     (chk_w  && (!m_axi_wvalid  || m_axi_wdata  != prev_w))))
            stab_viol <= stab_viol + 1;
        chk_ar  <= !rst && m_axi_arvalid && !m_axi_arready;
        chk_aw  <= !rst && m_axi_awvalid && !m_axi_awready;
        chk_w   <= !rst && m_axi_wvalid && !m_axi_wready;
        prev_ar <= m_axi_araddr;
        prev_aw <= m_axi_awaddr;
        prev_w  <= m_axi_wdata;
    end

    // ---------------- checking helpers ----------------
    int checks = 0, failures = 0;
    logic [31:0] exp_wa[$], exp_wd[$], exp_r[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Word-level reference: word i reads src+4i, then writes dst+4i, aborting on injected errors.
    task automatic model_xfer(input logic [31:0] s, input logic [31:0] d, input int unsigned l,
                              input int unsigned re, input int unsigned we,
                              output logic err, output int unsigned left);
        exp_wa.delete(); exp_wd.delete(); exp_r.delete();
        err = 1'b0;
        left = l;
        for (int unsigned i = 0; i < l; i++) begin
            logic [31:0] sa, da;
            sa = (s & ~32'd3) + 32'(4 * i);
            da = (d & ~32'd3) + 32'(4 * i);
            exp_r.push_back(sa);
            if (i == re) begin err = 1'b1; break; end
            exp_wa.push_back(da);
            exp_wd.push_back(mdl[sa[11:2]]);
            mdl[da[11:2]] = mdl[sa[11:2]];
            if (i == we) begin err = 1'b1; break; end
            left--;
        end
    endtask

    task automatic check_logs(input string tag);
        int unsigned bad;
        chk({tag, "_nreads"}, rlog.size(), exp_r.size());
        chk({tag, "_nwrites"}, wlog_a.size(), exp_wa.size());
        bad = 0;
        for (int i = 0; i < rlog.size() && i < exp_r.size(); i++)
            if (rlog[i] !== exp_r[i]) bad++;
        for (int i = 0; i < wlog_a.size() && i < exp_wa.size(); i++)
            if (wlog_a[i] !== exp_wa[i] || wlog_d[i] !== exp_wd[i]) bad++;
        chk({tag, "_log_entries_bad"}, bad, 0);
        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== mdl[i]) bad++;
        chk({tag, "_mem_words_bad"}, bad, 0);
    endtask

    // Caller sits #1 after a posedge; returns in the done cycle (cyc counts from the start cycle).
    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int unsigned l,
                            input logic fm, input string tag, output int unsigned cyc);
        start = 1'b1; src_addr = s; dst_addr = d; len = 16'(l); fill_mode = fm;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        chk({tag, "_busy_after_start"}, busy, 1);
        while (!done && cyc < LIMIT) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_done_seen"}, done, 1);
        chk({tag, "_busy_at_done"}, busy, 0);
    endtask

    task automatic exec(input string tag, input logic [31:0] s, input logic [31:0] d,
                        input int unsigned l, input int unsigned re, input int unsigned we,
                        output logic derr, output int unsigned dleft, output int unsigned cyc);
        logic        merr;
        int unsigned mleft;
        rd_err = re; wr_err = we;
        run_xfer(s, d, l, 1'b0, tag, cyc);
        derr = error; dleft = 32'(words_left);
        model_xfer(s, d, l, re, we, merr, mleft);
        chk({tag, "_error"}, derr, merr);
        chk({tag, "_words_left"}, dleft, mleft);
        check_logs(tag);
    endtask

    typedef struct {
        logic [31:0] src, dst;
        int unsigned len, rd_e, wr_e, awl, wl, lat;
        logic        exp_err;
        int unsigned exp_left, exp_writes;
        int          exp_cyc;
    } vec_t;

    vec_t vt [8];

    initial begin
        logic        derr;
        int unsigned dleft, cyc, ndone;
        string       tag;

        vt[0] = '{32'h0000_0000, 32'h0000_0100, 4, NONE, NONE, 0, 0, 0, 1'b0, 0, 4, 18};
        vt[1] = '{32'h0000_0000, 32'h0000_0040, 0, NONE, NONE, 0, 0, 0, 1'b0, 0, 0, 2};
        vt[2] = '{32'h0000_0010, 32'h0000_0180, 2, NONE, NONE, 0, 3, 0, 1'b0, 0, 2, -1};
        vt[3] = '{32'h0000_0020, 32'h0000_0200, 5, 2,    NONE, 0, 0, 0, 1'b1, 3, 2, -1};
        vt[4] = '{32'h0000_0040, 32'h0000_0280, 4, NONE, 1,    0, 0, 0, 1'b1, 3, 2, -1};
        vt[5] = '{32'hFFFF_FFF8, 32'h0000_0300, 4, NONE, NONE, 0, 0, 0, 1'b0, 0, 4, 18};
        vt[6] = '{32'h0000_0003, 32'h0000_0383, 1, NONE, NONE, 0, 0, 0, 1'b0, 0, 1, 6};
        vt[7] = '{32'h0000_0050, 32'h0000_0400, 3, NONE, NONE, 2, 2, 2, 1'b0, 0, 3, -1};

        rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        fill_mode = 1'b0; fill_data = '0; init_mem = 1'b1;
        ar_lat = 0; r_lat = 0; aw_lat = 0; w_lat = 0; b_lat = 0; rd_err = NONE; wr_err = NONE;
        for (int i = 0; i < 1024; i++) mdl[i] = 32'(i + 1);
        repeat (3) @(posedge clk);
        #1;
        init_mem = 1'b0;
        chk("reset_ctrl", {busy, done, error, words_left}, 0);
        chk("reset_valids", {m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 0);
        chk("reset_addr_data", {m_axi_araddr, m_axi_awaddr}, 0);
        chk("reset_wdata_wstrb", {m_axi_wdata, m_axi_wstrb}, {32'h0, 4'hF});
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 8; v++) begin
            tag = $sformatf("vec%0d", v);
            aw_lat = vt[v].awl; w_lat = vt[v].wl;
            ar_lat = vt[v].lat; r_lat = vt[v].lat; b_lat = vt[v].lat;
            exec(tag, vt[v].src, vt[v].dst, vt[v].len, vt[v].rd_e, vt[v].wr_e, derr, dleft, cyc);
            chk({tag, "_tbl_error"}, derr, vt[v].exp_err);
            chk({tag, "_tbl_left"}, dleft, vt[v].exp_left);
            chk({tag, "_tbl_writes"}, wlog_a.size(), vt[v].exp_writes);
            if (vt[v].exp_cyc >= 0) chk({tag, "_cycles"}, cyc, vt[v].exp_cyc);
            if (vt[v].len == 0) chk({tag, "_no_ar_aw"}, ar_cyc + aw_cyc, 0);
            @(posedge clk); #1;
            chk({tag, "_done_one_cycle"}, done, 0);
        end

        // Reset while the engine holds awvalid in WR.
        ar_lat = 0; r_lat = 0; b_lat = 0; aw_lat = 8; w_lat = 8; rd_err = NONE; wr_err = NONE;
        start = 1'b1; src_addr = 32'h0; dst_addr = 32'h500; len = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!m_axi_awvalid && cyc < 50) begin @(posedge clk); #1; cyc++; end
        chk("rstmid_reached_wr", m_axi_awvalid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_outputs", {m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid,
                               m_axi_bready, busy, done}, 0);
        rst = 1'b0;
        ndone = 0;
        repeat (10) begin @(posedge clk); #1; if (done) ndone++; end
        chk("rstmid_no_done", ndone, 0);
        aw_lat = 0; w_lat = 0;
        exec("rstmid_restart", 32'h0, 32'h500, 3, NONE, NONE, derr, dleft, cyc);
        chk("rstmid_restart_cycles", cyc, 14);

        for (int n = 0; n < 24; n++) begin
            tag = $sformatf("rand%0d", n);
            ar_lat = $urandom_range(0, 2); r_lat = $urandom_range(0, 2); b_lat = $urandom_range(0, 2);
            aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3);
            exec(tag, $urandom, $urandom, $urandom_range(0, 6), $urandom_range(0, 9),
                 $urandom_range(0, 9), derr, dleft, cyc);
        end

`ifdef DMAC_FILL_EN
        ar_lat = 0; r_lat = 0; b_lat = 0; aw_lat = 1; w_lat = 0; rd_err = NONE; wr_err = NONE;
        fill_data = 32'hDEAD_BEEF;
        run_xfer(32'h0, 32'h200, 3, 1'b1, "fill", cyc);
        fill_mode = 1'b0;
        chk("fill_error", error, 0);
        chk("fill_ar_cycles", ar_cyc, 0);
        exp_r.delete(); exp_wa.delete(); exp_wd.delete();
        for (int i = 0; i < 3; i++) begin
            exp_wa.push_back(32'h200 + 32'(4 * i));
            exp_wd.push_back(32'hDEAD_BEEF);
            mdl[(32'h200 >> 2) + i] = 32'hDEAD_BEEF;
        end
        check_logs("fill");
`endif

        chk("valid_stability_violations", stab_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
